// File: rtl/sig_capture_pkg.sv
// Shared types for the sig_capture sample-capture block.
// The default timeout width is used only when SIG_CAPTURE_AUTO_EN is defined.
package sig_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DEFAULT_TIMEOUT_WIDTH = 12;

endpackage

// File: rtl/sig_capture_if.sv
// Sample, trigger and readback bundle for sig_capture.
// timed_out exists only when SIG_CAPTURE_AUTO_EN is defined.
interface sig_capture_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  en;
  logic [DATA_WIDTH-1:0] din;
  logic                  arm;
  logic [DATA_WIDTH-1:0] trig_level;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] dout;
  logic                  busy;
  logic                  done;
`ifdef SIG_CAPTURE_AUTO_EN
  logic                  timed_out;

  modport master (output en, din, arm, trig_level, rd_addr,
                  input  dout, busy, done, timed_out);
  modport slave  (input  en, din, arm, trig_level, rd_addr,
                  output dout, busy, done, timed_out);
`else
  modport master (output en, din, arm, trig_level, rd_addr,
                  input  dout, busy, done);
  modport slave  (input  en, din, arm, trig_level, rd_addr,
                  output dout, busy, done);
`endif
endinterface

// File: rtl/sig_capture_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port,
// read-before-write on an address collision.
module capture_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // NOTE: non-blocking assignment samples the old word, giving read-before-write for free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata <= '0;
    else      rdata <= mem[raddr];
  end

endmodule

// File: rtl/sig_capture.sv
// Triggered sample capture: waits for a rising crossing of trig_level, then
// records 2^ADDR_WIDTH samples. SIG_CAPTURE_AUTO_EN adds a trigger timeout.
module sig_capture
  import sig_capture_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8
`ifdef SIG_CAPTURE_AUTO_EN
 ,parameter int TIMEOUT_WIDTH = DEFAULT_TIMEOUT_WIDTH
`endif
) (
  input  logic          clk,
  input  logic          rst,
  sig_capture_if.slave  bus
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] prev;
  logic                  prev_valid;
  logic                  crossing;
  logic                  start;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;

  assign crossing = prev_valid && (prev < bus.trig_level) && (bus.din >= bus.trig_level);

`ifdef SIG_CAPTURE_AUTO_EN
  logic [TIMEOUT_WIDTH-1:0] to_cnt;
  logic                     timed_out_q;
  logic                     timeout_hit;

  assign timeout_hit   = (to_cnt == '1);
  assign start         = crossing || timeout_hit;
  assign bus.timed_out = timed_out_q;
`else
  assign start = crossing;
`endif

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    we    = 1'b0;
    waddr = wr_addr;
    case (state)
      ARMED: begin
        we    = bus.en && start;
        waddr = '0;
      end
      CAPTURE: we = bus.en;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wr_addr     <= '0;
      prev        <= '0;
      prev_valid  <= 1'b0;
`ifdef SIG_CAPTURE_AUTO_EN
      to_cnt      <= '0;
      timed_out_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          // Arming discards any crossing in the same cycle and forgets the last sample.
          if (bus.arm) begin
            state       <= ARMED;
            wr_addr     <= '0;
            prev_valid  <= 1'b0;
`ifdef SIG_CAPTURE_AUTO_EN
            to_cnt      <= '0;
            timed_out_q <= 1'b0;
`endif
          end
        end
        ARMED: begin
          if (bus.en) begin
            prev       <= bus.din;
            prev_valid <= 1'b1;
            if (crossing) begin
              state   <= CAPTURE;
              wr_addr <= ADDR_WIDTH'(1);
            end
`ifdef SIG_CAPTURE_AUTO_EN
            else if (timeout_hit) begin
              state       <= CAPTURE;
              wr_addr     <= ADDR_WIDTH'(1);
              timed_out_q <= 1'b1;
            end else begin
              to_cnt <= to_cnt + TIMEOUT_WIDTH'(1);
            end
`endif
          end
        end
        CAPTURE: begin
          if (bus.en) begin
            wr_addr <= wr_addr + ADDR_WIDTH'(1);
            if (wr_addr == '1) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == ARMED) || (state == CAPTURE);
  assign bus.done = (state == DONE);

  capture_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.din),
    .raddr (bus.rd_addr),
    .rdata (bus.dout)
  );

endmodule

// File: tb/tb_sig_capture.sv
// Scoreboard bench for sig_capture (ADDR_WIDTH=4); covers the timeout path
// when SIG_CAPTURE_AUTO_EN is defined.
module tb_sig_capture;

  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sig_capture_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef SIG_CAPTURE_AUTO_EN
  sig_capture #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_WIDTH(4)) dut (
    .clk (clk), .rst (rst), .bus (bus));
`else
  sig_capture #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk), .rst (rst), .bus (bus));
`endif

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] mon_exp;
  logic          rd_req   = 1'b0;
  logic          rd_req_q = 1'b0;

  // A read issued before an edge has its data on dout after that edge.
  always @(posedge clk) rd_req_q <= rd_req;

  always @(negedge clk) begin
    if (rd_req_q) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL readback: dout=%h with no expected entry", bus.dout);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.dout !== mon_exp) begin
          failures++;
          $display("FAIL readback addr_prev=%0d: dout=%h expected %h",
                   rd_req_q ? bus.rd_addr : '0, bus.dout, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [DW-1:0] d);
    bus.en  = 1'b1;
    bus.din = d;
    tick();
    bus.en  = 1'b0;
  endtask

  task automatic gap();
    bus.en  = 1'b0;
    bus.din = 8'h55;
    tick();
  endtask

  task automatic do_arm();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  // Reads n consecutive addresses; expected word at first+i is base+i.
  task automatic read_range(input int first, input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      bus.rd_addr = AW'(first + i);
      exp_q.push_back(base + DW'(i));
      rd_req = 1'b1;
      tick();
    end
    rd_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    bus.en = 1'b0; bus.din = '0; bus.arm = 1'b0;
    bus.trig_level = 8'h80; bus.rd_addr = '0;

    // Reset, then a full ramp with no arm must leave the block idle.
    repeat (3) tick();
    check("reset_dout", 32'(bus.dout), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_done", 32'(bus.done), 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) sample(8'(i));
    check("noarm_busy", 32'(bus.busy), 32'h0);
    check("noarm_done", 32'(bus.done), 32'h0);

    // Basic capture: 0x70, 0x7F do not cross; 0x80 triggers.
    do_arm();
    check("arm_busy", 32'(bus.busy), 32'h1);
    sample(8'h70);
    sample(8'h7F);
    for (int i = 0; i < 16; i++) begin
      sample(8'h80 + 8'(i));
      if (i == 14) check("basic_done_early", 32'(bus.done), 32'h0);
    end
    check("basic_done", 32'(bus.done), 32'h1);
    check("basic_busy", 32'(bus.busy), 32'h0);
    sample(8'h00);
    sample(8'hFF);
    check("done_holds", 32'(bus.done), 32'h1);
    read_range(0, 16, 8'h80);

    // Re-arm with a sample in the arm cycle; first sample after arming cannot trigger.
    bus.arm = 1'b1; bus.en = 1'b1; bus.din = 8'h10;
    tick();
    bus.arm = 1'b0; bus.en = 1'b0;
    check("rearm_done", 32'(bus.done), 32'h0);
    check("rearm_busy", 32'(bus.busy), 32'h1);
    sample(8'hFF);
    sample(8'h10);
    sample(8'h90);
    for (int i = 1; i < 16; i++) begin
      sample(8'h90 + 8'(i));
      if (i == 14) check("guard_done_early", 32'(bus.done), 32'h0);
    end
    check("guard_done", 32'(bus.done), 32'h1);
    read_range(0, 16, 8'h90);

    // Gapped strobes: en=0 cycles carry junk data that must not be written.
    do_arm();
    sample(8'h00);
    gap();
    sample(8'hA0);
    for (int i = 1; i < 16; i++) begin
      gap();
      sample(8'hA0 + 8'(i));
      if (i == 14) check("gap_done_early", 32'(bus.done), 32'h0);
    end
    check("gap_done", 32'(bus.done), 32'h1);
    read_range(0, 16, 8'hA0);

    // trig_level=0 never triggers: 17 strobes would otherwise finish a capture.
    do_arm();
    bus.trig_level = 8'h00;
    for (int k = 0; k < 17; k++) sample(k[0] ? 8'hFF : 8'h00);
    check("trig0_done", 32'(bus.done), 32'h0);
    check("trig0_busy", 32'(bus.busy), 32'h1);
    rst = 1'b0;
    #1;
    check("trig0_rst_busy", 32'(bus.busy), 32'h0);
    tick();
    rst = 1'b1;
    bus.trig_level = 8'h80;

    // Reset after five capture writes: partial data survives.
    do_arm();
    sample(8'h00);
    sample(8'hC0);
    for (int i = 1; i < 5; i++) sample(8'hC0 + 8'(i));
    check("partial_busy", 32'(bus.busy), 32'h1);
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'h0);
    check("midrst_done", 32'(bus.done), 32'h0);
    check("midrst_dout", 32'(bus.dout), 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_idle_busy", 32'(bus.busy), 32'h0);
    read_range(0, 5, 8'hC0);
    read_range(5, 1, 8'hA5);

`ifdef SIG_CAPTURE_AUTO_EN
    // Timeout: 15 flat strobes, capture starts on the 16th.
    do_arm();
    check("to_arm_clear", 32'(bus.timed_out), 32'h0);
    for (int k = 1; k <= 31; k++) begin
      sample((k <= 15) ? 8'h00 : 8'(k));
      if (k == 15) check("to_not_yet", 32'(bus.timed_out), 32'h0);
      if (k == 16) check("to_fired", 32'(bus.timed_out), 32'h1);
      if (k == 30) check("to_done_early", 32'(bus.done), 32'h0);
    end
    check("to_done", 32'(bus.done), 32'h1);
    read_range(0, 16, 8'h10);
    do_arm();
    check("to_rearm_clear", 32'(bus.timed_out), 32'h0);
    check("to_rearm_busy", 32'(bus.busy), 32'h1);
`endif

    tick();
    tick();
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
